// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for a shared 32-to-1 bus mux: drives Sel/Enable and holds
// each grant until the owner releases, drops its request or hits the burst limit.
//
//  state | meaning
//  IDLE  | no owner; arbitrate pending requests from Ptr upward
//  GRANT | Sel owns the bus; watch for release, count burst cycles
module bus_rr_arbiter #(
    parameter int MaxBurst = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Req,
    input  logic        Last,
    output logic [31:0] Grant,
    output logic [4:0]  Sel,
    output logic        Enable,
    output logic        Busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [7:0] BurstLast = 8'(MaxBurst - 1);
    localparam bit         Limited   = (MaxBurst != 0);

    logic [0:0] state;
    logic [4:0] Ptr;
    logic [7:0] Cnt;

    logic       pickValid;
    logic [4:0] pickIdx;
    logic       relNow;

    // Scan from the highest offset down so the lowest offset from Ptr wins.
    function automatic logic [5:0] rrPick(input logic [31:0] req, input logic [4:0] ptr);
        logic [4:0] cand;
        logic [5:0] res;
        res = {1'b0, ptr};
        for (int i = 31; i >= 0; i--) begin
            cand = ptr + 5'(i);
            if (req[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    assign {pickValid, pickIdx} = rrPick(Req, Ptr);

    assign relNow = !Req[Sel] || Last || (Limited && (Cnt == BurstLast));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            Ptr    <= 5'd0;
            Cnt    <= 8'd0;
            Grant  <= 32'd0;
            Sel    <= 5'd0;
            Enable <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        Sel    <= pickIdx;
                        Grant  <= 32'd1 << pickIdx;
                        Enable <= 1'b1;
                        Busy   <= 1'b1;
                        Cnt    <= 8'd0;
                        state  <= GRANT;
                    end else begin
                        Grant  <= 32'd0;
                        Enable <= 1'b0;
                        Busy   <= 1'b0;
                    end
                end
                GRANT: begin
                    // All release causes collapse into one pointer advance.
                    if (relNow) begin
                        Grant  <= 32'd0;
                        Enable <= 1'b0;
                        Busy   <= 1'b0;
                        Ptr    <= Sel + 5'd1;
                        state  <= IDLE;
                    end else if (Cnt != 8'hFF) begin
                        Cnt <= Cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    Grant  <= 32'd0;
                    Enable <= 1'b0;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
